sru_bitstream_loader: RTL



---
 rtl/sru_bitstream_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sru_bitstream_loader.sv
// Word-parallel to bit-serial configuration loader for the SRU config port.
// Accepts WORD_WIDTH words over valid/ready and emits exactly CFG_SIZE bits LSB first.
module sru_bitstream_loader #(
    parameter int CFG_SIZE   = 64,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [WORD_WIDTH-1:0] WordIn,
    input  logic                  WordValid,
    output logic                  WordReady,
    output logic                  bitstreamSerialIn,
    output logic                  bitstreamValid,
    output logic                  Busy,
    output logic                  Done
);
    localparam int CNT_W  = $clog2(WORD_WIDTH + 1);
    localparam int SENT_W = $clog2(CFG_SIZE + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t                state_reg;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic [WORD_WIDTH-1:0] shift_src;
    logic [WORD_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]      word_bits_reg;
    logic [CNT_W-1:0]      word_bits_load;
    logic [SENT_W-1:0]     sent_reg;
    logic [SENT_W-1:0]     remaining;
    logic                  ready_reg;
    logic                  valid_reg;
    logic                  serial_reg;
    logic                  busy_reg;
    logic                  done_reg;

    // serial_reg holds the bit on the wire; shift_reg holds the bits still to come.
    // On accept the fresh word is the shift source, otherwise the register itself.
    assign shift_src = (state_reg == FETCH) ? WordIn : shift_reg;

    generate
        for (genvar gi = 0; gi < WORD_WIDTH - 1; gi++) begin : g_shift
            assign shift_next[gi] = shift_src[gi + 1];
        end
    endgenerate
    assign shift_next[WORD_WIDTH-1] = 1'b0;

    // The last word may carry fewer useful bits than WORD_WIDTH.
    assign remaining      = SENT_W'(CFG_SIZE) - sent_reg;
    assign word_bits_load = (int'(remaining) >= WORD_WIDTH) ? CNT_W'(WORD_WIDTH)
                                                            : CNT_W'(remaining);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            word_bits_reg <= '0;
            sent_reg      <= '0;
            ready_reg     <= 1'b0;
            valid_reg     <= 1'b0;
            serial_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else if (Abort && (state_reg == FETCH || state_reg == SHIFT)) begin
            state_reg     <= IDLE;
            word_bits_reg <= '0;
            ready_reg     <= 1'b0;
            valid_reg     <= 1'b0;
            serial_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (Start) begin
                        state_reg <= FETCH;
                        sent_reg  <= '0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (WordValid) begin
                        state_reg     <= SHIFT;
                        shift_reg     <= shift_next;
                        serial_reg    <= shift_src[0];
                        word_bits_reg <= word_bits_load;
                        ready_reg     <= 1'b0;
                        valid_reg     <= 1'b1;
                    end
                end
                SHIFT: begin
                    sent_reg      <= sent_reg + 1'b1;
                    word_bits_reg <= word_bits_reg - 1'b1;
                    if (word_bits_reg == CNT_W'(1)) begin
                        valid_reg  <= 1'b0;
                        serial_reg <= 1'b0;
                        if (sent_reg == SENT_W'(CFG_SIZE - 1)) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= FETCH;
                            ready_reg <= 1'b1;
                        end
                    end else begin
                        shift_reg  <= shift_next;
                        serial_reg <= shift_src[0];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign WordReady         = ready_reg;
    assign bitstreamValid    = valid_reg;
    assign bitstreamSerialIn = serial_reg;
    assign Busy              = busy_reg;
    assign Done              = done_reg;
endmodule
